// File: rtl/rnn_input_feeder_if.sv
// Host/core-facing bundle for rnn_input_feeder: push port, sequence control
// and the fetch port that feeds the RNN core.
interface rnn_input_feeder_if #(
    parameter int AW     = 4,
    parameter int DATA_W = 32
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              busy;
    logic              i_en;
    logic [DATA_W-1:0] idata;
    logic              ready;
    logic              full;
    logic [AW:0]       count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, start, busy, i_en,
        input  idata, ready, full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, start, busy, i_en,
        output idata, ready, full, count, overflow, underflow
    );
endinterface

// File: rtl/rnn_input_feeder.sv
// Input-vector FIFO feeding the RNN core: host pushes vectors, the core pulls
// one per i_en strobe, and a small FSM raises ready once enough are buffered.
module rnn_input_feeder #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int START_LEVEL = 1,
    parameter int DATA_W      = 32
) (
    input logic               clk,
    input logic               reset,
    rnn_input_feeder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, LAUNCH, RUN} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] START_C = (AW+1)'(START_LEVEL);

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic [AW:0]       cnt_nxt;
    logic [DATA_W-1:0] idata_q;
    logic              ready_q;
    logic              full_q;
    logic              ovf_q;
    logic              udf_q;
    logic              pop;
    logic              push;
    logic              drop;
    logic              starve;
    logic              clr;

    // A push into a full FIFO is still accepted when a pop frees the slot in
    // the same cycle; an empty FIFO never forwards a same-cycle push.
    always_comb begin
        pop     = bus.i_en && (cnt != '0);
        push    = bus.wr_en && ((cnt != DEPTH_C) || pop);
        drop    = bus.wr_en && !push;
        starve  = bus.i_en && (cnt == '0);
        clr     = (state == IDLE) && bus.start;
        cnt_nxt = cnt;
        if (push && !pop)
            cnt_nxt = cnt + 1'b1;
        else if (pop && !push)
            cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            idata_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                idata_q <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            cnt    <= cnt_nxt;
            full_q <= (cnt_nxt == DEPTH_C);
            // A fault in the same cycle as the clearing start still sticks.
            ovf_q  <= (ovf_q && !clr) || drop;
            udf_q  <= (udf_q && !clr) || starve;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.start)
                        state <= ARMED;
                end
                ARMED: begin
                    if (cnt >= START_C) begin
                        state   <= LAUNCH;
                        ready_q <= 1'b1;
                    end
                end
                LAUNCH: begin
                    if (bus.busy) begin
                        state   <= RUN;
                        ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    ready_q <= 1'b0;
                    if (!bus.busy)
                        state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.idata     = idata_q;
    assign bus.ready     = ready_q;
    assign bus.full      = full_q;
    assign bus.count     = cnt;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule
